// File: rtl/isp_oecf_pwl.sv
// Per-Bayer-channel piecewise-linear OECF with double-buffered knot tables and a 3-stage pixel pipeline.
// Define ISP_OECF_INTERP_EN for linear interpolation between knots; otherwise the lower knot is output.
module isp_oecf_pwl #(
    parameter int BITS     = 12,
    parameter int LUT_BITS = 6,
    parameter int BAYER    = 0
) (
    input  logic                pclk,
    input  logic                rst_n,
    input  logic                bypass,
    input  logic                tbl_wen,
    input  logic                tbl_ren,
    input  logic [1:0]          tbl_chan,
    input  logic [LUT_BITS:0]   tbl_addr,
    input  logic [BITS-1:0]     tbl_wdata,
    output logic [BITS-1:0]     tbl_rdata,
    input  logic                tbl_commit,
    output logic                tbl_pending,
    input  logic                in_href,
    input  logic                in_vsync,
    input  logic [BITS-1:0]     in_data,
    output logic                out_href,
    output logic                out_vsync,
    output logic [BITS-1:0]     out_data
);

    localparam int FRAC = BITS - LUT_BITS;
    localparam int K    = (1 << LUT_BITS) + 1;
    localparam int MAXV = (1 << BITS) - 1;
    localparam int SW   = BITS + FRAC + 2;
    localparam logic [LUT_BITS:0] LAST     = {1'b1, {LUT_BITS{1'b0}}};
    localparam logic [1:0]        BAYER_PH = 2'(BAYER);

    typedef enum logic {ST_IDLE, ST_PENDING} state_t;

    function automatic logic [BITS-1:0] ident_knot(input int k);
        int v;
        v = k << FRAC;
        if (v > MAXV) v = MAXV;
        return v[BITS-1:0];
    endfunction

    // knot_q[bank][channel][knot]; the bank opposite active_bank_q is the host-visible shadow
    logic [BITS-1:0] knot_q [2][4][K];
    logic            active_bank_q;
    state_t          state_q, state_d;
    logic            swap;
    logic [BITS-1:0] rdata_q;
    logic [LUT_BITS:0] rd_addr;

    logic href_prev_q, vsync_prev_q, odd_pix_q, odd_line_q;
    logic vsync_rise;
    logic [1:0] fmt;
    logic [LUT_BITS:0] idx;
    logic [BITS-1:0] y0;

    logic            s1_href_q, s1_vsync_q, s1_byp_q;
    logic [BITS-1:0] s1_raw_q, s1_y0_q;
    logic            s2_href_q, s2_vsync_q, s2_byp_q;
    logic [BITS-1:0] s2_raw_q, s2_y0_q;
    logic            out_href_q, out_vsync_q;
    logic [BITS-1:0] out_data_q, out_data_d;
    logic [BITS-1:0] result;

`ifdef ISP_OECF_INTERP_EN
    logic [LUT_BITS:0]     idx_nxt;
    logic [BITS-1:0]       y1;
    logic [BITS-1:0]       s1_y1_q;
    logic [FRAC-1:0]       s1_frac_q;
    logic signed [BITS:0]  diff;
    logic signed [SW-1:0]  diff_ext, frac_ext, prod_d, s2_prod_q, sum;
`endif

    // ---------------- Knot tables ----------------
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 0; b < 2; b++)
                for (int c = 0; c < 4; c++)
                    for (int k = 0; k < K; k++)
                        knot_q[b][c][k] <= ident_knot(k);
        end else if (tbl_wen && (tbl_addr <= LAST)) begin
            knot_q[~active_bank_q][tbl_chan][tbl_addr] <= tbl_wdata;
        end
    end

    assign rd_addr = (tbl_addr <= LAST) ? tbl_addr : '0;

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else if (tbl_ren) begin
            rdata_q <= (tbl_addr <= LAST) ? knot_q[~active_bank_q][tbl_chan][rd_addr] : '0;
        end
    end

    // ---------------- Commit FSM ----------------
    assign vsync_rise = in_vsync & ~vsync_prev_q;

    always_comb begin
        state_d = state_q;
        swap    = 1'b0;
        case (state_q)
            ST_IDLE: if (tbl_commit) state_d = ST_PENDING;
            ST_PENDING: begin
                if (vsync_rise) begin
                    swap    = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            active_bank_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            active_bank_q <= active_bank_q ^ swap;
        end
    end

    // ---------------- Bayer phase tracking ----------------
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            href_prev_q  <= 1'b0;
            vsync_prev_q <= 1'b0;
            odd_pix_q    <= 1'b0;
            odd_line_q   <= 1'b0;
        end else begin
            href_prev_q  <= in_href;
            vsync_prev_q <= in_vsync;
            odd_pix_q    <= in_href ? ~odd_pix_q : 1'b0;
            if (in_vsync)
                odd_line_q <= 1'b0;
            else if (href_prev_q && !in_href)
                odd_line_q <= ~odd_line_q;
        end
    end

    // ---------------- Stage 1: knot fetch ----------------
    assign fmt = BAYER_PH ^ {odd_line_q, odd_pix_q};
    assign idx = {1'b0, in_data[BITS-1:FRAC]};
    assign y0  = knot_q[active_bank_q][fmt][idx];
`ifdef ISP_OECF_INTERP_EN
    assign idx_nxt = idx + 1'b1;
    assign y1      = knot_q[active_bank_q][fmt][idx_nxt];
`endif

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            s1_href_q  <= 1'b0;
            s1_vsync_q <= 1'b0;
            s1_byp_q   <= 1'b0;
            s1_raw_q   <= '0;
            s1_y0_q    <= '0;
`ifdef ISP_OECF_INTERP_EN
            s1_y1_q    <= '0;
            s1_frac_q  <= '0;
`endif
        end else begin
            s1_href_q  <= in_href;
            s1_vsync_q <= in_vsync;
            s1_byp_q   <= bypass;
            s1_raw_q   <= in_data;
            s1_y0_q    <= y0;
`ifdef ISP_OECF_INTERP_EN
            s1_y1_q    <= y1;
            s1_frac_q  <= in_data[FRAC-1:0];
`endif
        end
    end

    // ---------------- Stage 2: slope * fraction ----------------
`ifdef ISP_OECF_INTERP_EN
    always_comb begin
        diff     = $signed({1'b0, s1_y1_q}) - $signed({1'b0, s1_y0_q});
        diff_ext = SW'(diff);
        frac_ext = $signed({{(SW-FRAC){1'b0}}, s1_frac_q});
        prod_d   = diff_ext * frac_ext;
    end
`endif

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            s2_href_q  <= 1'b0;
            s2_vsync_q <= 1'b0;
            s2_byp_q   <= 1'b0;
            s2_raw_q   <= '0;
            s2_y0_q    <= '0;
`ifdef ISP_OECF_INTERP_EN
            s2_prod_q  <= '0;
`endif
        end else begin
            s2_href_q  <= s1_href_q;
            s2_vsync_q <= s1_vsync_q;
            s2_byp_q   <= s1_byp_q;
            s2_raw_q   <= s1_raw_q;
            s2_y0_q    <= s1_y0_q;
`ifdef ISP_OECF_INTERP_EN
            s2_prod_q  <= prod_d;
`endif
        end
    end

    // ---------------- Stage 3: add, clamp, blank ----------------
    always_comb begin
        result = s2_y0_q;
`ifdef ISP_OECF_INTERP_EN
        // arithmetic shift floors toward minus infinity for falling segments
        sum = $signed({{(FRAC+2){1'b0}}, s2_y0_q}) + (s2_prod_q >>> FRAC);
        if (sum[SW-1])
            result = '0;
        else if (|sum[SW-2:BITS])
            result = '1;
        else
            result = sum[BITS-1:0];
`endif
        out_data_d = '0;
        if (s2_href_q)
            out_data_d = s2_byp_q ? s2_raw_q : result;
    end

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            out_href_q  <= 1'b0;
            out_vsync_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            out_href_q  <= s2_href_q;
            out_vsync_q <= s2_vsync_q;
            out_data_q  <= out_data_d;
        end
    end

    assign tbl_rdata   = rdata_q;
    assign tbl_pending = (state_q == ST_PENDING);
    assign out_href    = out_href_q;
    assign out_vsync   = out_vsync_q;
    assign out_data    = out_data_q;

endmodule
